instr_cache: RTL and testbench

- Direct-mapped, read-only instruction cache. It is the responder to the fetch stage's instruction read.
- Fetch presents a PC each cycle and receives an instruction combinationally on a hit.
- On a miss it asserts a stall toward fetch and refills the whole line from backing memory using a req/valid handshake.
- Sits between the fetch stage and the instruction memory; replaces the purely combinational instruction memory path.

---
 rtl/instr_cache_pkg.sv | 26 ++
 rtl/icache_fill_fsm.sv | 87 ++++++++
 rtl/instr_cache.sv | 122 ++++++++++++
 tb/tb_instr_cache.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: nop encoding,
// refill FSM states and the PC field split derived from the geometry.
package instr_cache_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  typedef struct packed {
    logic [5:0] off_bits;
    logic [5:0] idx_bits;
    logic [5:0] tag_bits;
  } addr_split_t;

  function automatic addr_split_t addr_split(input int num_lines, input int line_words);
    addr_split_t s;
    s.off_bits = 6'($clog2(line_words) + 2);
    s.idx_bits = 6'($clog2(num_lines));
    s.tag_bits = 6'(32 - $clog2(line_words) - 2 - $clog2(num_lines));
    return s;
  endfunction

endpackage

// File: rtl/icache_fill_fsm.sv
// Line refill sequencer: walks one cache line word by word over the memory
// req/valid handshake and remembers whether an invalidate hit the line in flight.
module icache_fill_fsm
  import instr_cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int CW         = $clog2(LINE_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [31:0]   miss_base_i,
  input  logic          inv_i,
  input  logic          mem_valid_i,
  output fill_state_e   state_o,
  output logic          mem_req_o,
  output logic [31:0]   mem_addr_o,
  output logic [31:0]   base_o,
  output logic [CW-1:0] cnt_o,
  output logic          wr_en_o,
  output logic          last_o,
  output logic          abort_o
);

  fill_state_e   state_q;
  logic          req_q;
  logic [31:0]   addr_q;
  logic [31:0]   base_q;
  logic [CW-1:0] cnt_q;
  logic          abort_q;

  // Refill state, word counter, request address and abort flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= 32'h0000_0000;
      base_q  <= 32'h0000_0000;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_FILL;
            req_q   <= 1'b1;
            addr_q  <= miss_base_i;
            base_q  <= miss_base_i;
            cnt_q   <= '0;
            abort_q <= 1'b0;
          end
        end
        ST_FILL: begin
          if (inv_i) begin
            abort_q <= 1'b1;
          end
          // The final beat also clears abort, overriding a same-cycle invalidate.
          if (mem_valid_i) begin
            if (cnt_q == CW'(LINE_WORDS - 1)) begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
              cnt_q   <= '0;
              abort_q <= 1'b0;
            end else begin
              cnt_q  <= cnt_q + CW'(1);
              addr_q <= addr_q + 32'd4;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign state_o    = state_q;
  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;
  assign base_o     = base_q;
  assign cnt_o      = cnt_q;
  assign abort_o    = abort_q;
  assign wr_en_o    = (state_q == ST_FILL) && mem_valid_i;
  assign last_o     = wr_en_o && (cnt_q == CW'(LINE_WORDS - 1));

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache between fetch and instruction
// memory: zero-latency hit path, stall plus whole-line refill on a miss.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PcF,
  output logic [31:0] InstrF,
  output logic        StallF,
  input  logic        Inv,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemRdata,
  input  logic        MemValid
);

  localparam addr_split_t SPLIT = addr_split(NUM_LINES, LINE_WORDS);
  localparam int OB = int'(SPLIT.off_bits);
  localparam int IB = int'(SPLIT.idx_bits);
  localparam int TB = int'(SPLIT.tag_bits);
  localparam int CW = OB - 2;

  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
  logic [TB-1:0]        tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;

  fill_state_e   state_s;
  logic [31:0]   base_s;
  logic [CW-1:0] cnt_s;
  logic          wr_en_s;
  logic          last_s;
  logic          abort_s;

  logic [CW-1:0] off_s;
  logic [IB-1:0] idx_s;
  logic [TB-1:0] tag_s;
  logic [IB-1:0] fill_idx_s;
  logic [TB-1:0] fill_tag_s;
  logic [31:0]   miss_base_s;
  logic          hit_s;
  logic          start_s;
  logic          unused_s;

  assign off_s       = PcF[OB-1:2];
  assign idx_s       = PcF[OB+IB-1:OB];
  assign tag_s       = PcF[31:OB+IB];
  assign fill_idx_s  = base_s[OB+IB-1:OB];
  assign fill_tag_s  = base_s[31:OB+IB];
  assign miss_base_s = {PcF[31:OB], {OB{1'b0}}};
  assign unused_s    = ^{PcF[1:0], base_s[OB-1:0]};

  assign hit_s   = (state_s == ST_IDLE) && valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  // An invalidate in IDLE suppresses the refill that a miss would otherwise start.
  assign start_s = (state_s == ST_IDLE) && !hit_s && !Inv;

  icache_fill_fsm #(
    .LINE_WORDS (LINE_WORDS),
    .CW         (CW)
  ) u_fill_fsm (
    .clk_i       (CLK),
    .rst_ni      (Reset),
    .start_i     (start_s),
    .miss_base_i (miss_base_s),
    .inv_i       (Inv),
    .mem_valid_i (MemValid),
    .state_o     (state_s),
    .mem_req_o   (MemReq),
    .mem_addr_o  (MemAddr),
    .base_o      (base_s),
    .cnt_o       (cnt_s),
    .wr_en_o     (wr_en_s),
    .last_o      (last_s),
    .abort_o     (abort_s)
  );

  // Fetch-side lookup result
  always_comb begin
    if (hit_s) begin
      InstrF = data_q[idx_s][off_s];
    end else begin
      InstrF = INSTR_NOP;
    end
    StallF = !hit_s;
  end

  // Next valid bits: invalidate wins, otherwise a clean final beat validates the line
  always_comb begin
    valid_d = valid_q;
    if (Inv) begin
      valid_d = '0;
    end else if (last_s && !abort_s) begin
      valid_d[fill_idx_s] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only reset storage
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data and tag arrays written by the refill
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      data_q[fill_idx_s][cnt_s] <= MemRdata;
    end
    if (last_s) begin
      tag_q[fill_idx_s] <= fill_tag_s;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Randomized and directed bench for instr_cache against a line-level cache model.
module tb_instr_cache;

  localparam int NL = 16;
  localparam int LW = 4;

  logic        CLK      = 1'b0;
  logic        Reset    = 1'b1;
  logic [31:0] PcF      = 32'h0;
  logic        Inv      = 1'b0;
  logic [31:0] MemRdata = 32'h0;
  logic        MemValid = 1'b0;
  logic [31:0] InstrF;
  logic [31:0] MemAddr;
  logic        StallF;
  logic        MemReq;

  always #5 CLK = ~CLK;

  instr_cache #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .PcF      (PcF),
    .InstrF   (InstrF),
    .StallF   (StallF),
    .Inv      (Inv),
    .MemReq   (MemReq),
    .MemAddr  (MemAddr),
    .MemRdata (MemRdata),
    .MemValid (MemValid)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model: which tag each line holds, plus the single outstanding refill.
  bit          m_valid [NL];
  logic [23:0] m_tag   [NL];
  bit          m_fill;
  logic [31:0] m_base;
  int          m_beats;
  bit          m_abort;

  int          mem_mode;   // 0: valid tied high, 1: fixed wait, 2: random
  int          mem_wait;
  int          wcnt;
  bit          s_req, s_valid, last_stall;
  logic [31:0] last_instr;

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return !m_fill && m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_fill = 1'b0; m_beats = 0; m_abort = 1'b0; wcnt = 0;
  endtask

  task automatic model_clear_all();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_step();
    if (m_fill) begin
      if (Inv) begin
        model_clear_all();
        m_abort = 1'b1;
      end
      if (MemValid) begin
        if (m_beats == LW - 1) begin
          m_tag[m_base[7:4]] = m_base[31:8];
          if (!m_abort) m_valid[m_base[7:4]] = 1'b1;
          m_fill = 1'b0; m_abort = 1'b0; m_beats = 0;
        end else begin
          m_beats++;
        end
      end
    end else if (Inv) begin
      model_clear_all();
    end else if (!m_hit(PcF)) begin
      m_fill = 1'b1; m_base = {PcF[31:4], 4'h0}; m_beats = 0; m_abort = 1'b0;
    end
  endtask

  // One clock: compare at the falling edge, advance model at the rising edge, drive memory.
  task automatic cycle();
    bit exp_hit;
    @(negedge CLK);
    s_req = MemReq; s_valid = MemValid; last_stall = StallF; last_instr = InstrF;
    if (Reset) begin
      exp_hit = m_hit(PcF);
      check("stall", 32'(StallF), 32'(!exp_hit));
      check("instr", InstrF, exp_hit ? pattern(PcF) : 32'h0);
      check("memreq", 32'(MemReq), 32'(m_fill));
      if (m_fill) check("memaddr", MemAddr, m_base + 32'(4 * m_beats));
    end else begin
      check("rst_stall", 32'(StallF), 32'd1);
      check("rst_instr", InstrF, 32'h0);
      check("rst_memreq", 32'(MemReq), 32'd0);
      check("rst_memaddr", MemAddr, 32'h0);
    end
    @(posedge CLK);
    if (Reset) model_step();
    #1;
    if (s_req && s_valid) wcnt = 0;
    else if (s_req) wcnt++;
    case (mem_mode)
      0:       MemValid = 1'b1;
      1:       MemValid = MemReq && (wcnt >= mem_wait);
      default: MemValid = 1'($urandom_range(0, 1));
    endcase
    MemRdata = MemReq ? pattern(MemAddr) : $urandom();
  endtask

  task automatic measure(input logic [31:0] a, output int n);
    PcF = a;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (!last_stall) break;
      n++;
    end
  endtask

  task automatic wait_fill_done();
    for (int k = 0; k < 200; k++) begin
      if (!m_fill) break;
      cycle();
    end
    check("fill_done", 32'(m_fill), 32'd0);
  endtask

  int n;

  initial begin
    mem_mode = 0; mem_wait = 0;
    model_reset();
    #1 Reset = 1'b0;
    repeat (3) cycle();
    Reset = 1'b1;

    // Cold miss on line 0 with zero-wait memory
    measure(32'h0, n);
    check("penalty_0x0", 32'(n), 32'd5);
    check("instr_0x0", last_instr, 32'hC0DE_0000);

    // Rest of line 0 hits without stalling
    PcF = 32'h4; cycle(); check("hit_0x4", 32'(last_stall), 32'd0);
    PcF = 32'h8; cycle(); check("hit_0x8", 32'(last_stall), 32'd0);
    check("instr_0x8", last_instr, 32'hC0DE_0008);
    PcF = 32'hC; cycle(); check("hit_0xC", 32'(last_stall), 32'd0);

    // Same-index conflict evicts line 0
    measure(32'h100, n);
    check("penalty_0x100", 32'(n), 32'd5);
    check("instr_0x100", last_instr, 32'hC0DE_0100);
    measure(32'h0, n);
    check("penalty_reload_0x0", 32'(n), 32'd5);

    // Three wait cycles per word
    mem_mode = 1; mem_wait = 3;
    measure(32'h24, n);
    check("penalty_wait3", 32'(n), 32'd17);
    check("instr_0x24", last_instr, 32'hC0DE_0024);
    mem_mode = 0;

    // Invalidate during the 0x200 refill
    PcF = 32'h200; cycle(); cycle();
    Inv = 1'b1; cycle(); Inv = 1'b0;
    wait_fill_done();
    measure(32'h200, n);
    check("penalty_after_inv_0x200", 32'(n), 32'd5);
    measure(32'h0, n);
    check("penalty_after_inv_0x0", 32'(n), 32'd5);
    measure(32'h20, n);
    check("penalty_after_inv_0x20", 32'(n), 32'd5);

    // Redirect during the 0x300 refill
    PcF = 32'h300; cycle(); cycle();
    PcF = 32'h430;
    wait_fill_done();
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (!last_stall) break;
    end
    check("redirect_hit_0x430", 32'(last_stall), 32'd0);
    PcF = 32'h300; cycle();
    check("hit_0x300", 32'(last_stall), 32'd0);
    check("instr_0x300", last_instr, 32'hC0DE_0300);

    // Asynchronous reset during beat 2 of a refill
    PcF = 32'h500; cycle();
    for (int k = 0; k < 20; k++) begin
      if (m_fill && m_beats == 2) break;
      cycle();
    end
    check("reached_beat2", 32'(m_beats), 32'd2);
    #2 Reset = 1'b0;
    #1;
    check("async_memreq", 32'(MemReq), 32'd0);
    check("async_stall", 32'(StallF), 32'd1);
    model_reset();
    cycle(); cycle();
    Reset = 1'b1;
    measure(32'h500, n);
    check("penalty_after_reset", 32'(n), 32'd5);

    // Randomized traffic over a few conflicting tags
    mem_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        PcF = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
            | (32'($urandom_range(0, 3)) << 2);
      Inv = ($urandom_range(0, 39) == 0);
      cycle();
    end
    Inv = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
